// File: rtl/axi_write_responder_pkg.sv
// Shared encodings for the AXI write responder: burst types, response codes
// and the controller state type.
package axi_write_responder_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for an AXI burst. INCR aligns to the beat size and
// steps by one beat; every other burst type holds the address.
module axi_burst_addr_gen
    import axi_write_responder_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] aligned;

    assign step    = ADDR_W'(1) << size;
    assign aligned = cur_addr & ~(step - ADDR_W'(1));

    // Wraps modulo 2**ADDR_W; 4 KB crossings are deliberately not checked.
    assign next_addr = (burst == AXI_BURST_INCR) ? aligned + step : cur_addr;

endmodule

// File: rtl/axi_write_responder.sv
// AXI4 write-channel responder: one outstanding AW/W/B transaction turned into
// word-wide memory writes. Malformed bursts are drained and answered SLVERR.
module axi_write_responder
    import axi_write_responder_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_NBYTES = AXI_DATA_W / 8,
    parameter int AXI_BYTE_W = $clog2(AXI_NBYTES),
    parameter int AXI_ID_W   = 1,
    parameter int MEM_ADDR_W = AXI_ADDR_W - AXI_BYTE_W
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  axi_awvalid,
    input  logic [AXI_ADDR_W-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic [AXI_ID_W-1:0]   axi_awid,
    output logic                  axi_awready,

    input  logic                  axi_wvalid,
    input  logic [AXI_DATA_W-1:0] axi_wdata,
    input  logic [AXI_NBYTES-1:0] axi_wstrb,
    input  logic                  axi_wlast,
    output logic                  axi_wready,

    output logic                  axi_bvalid,
    output logic [1:0]            axi_bresp,
    output logic [AXI_ID_W-1:0]   axi_bid,
    input  logic                  axi_bready,

    output logic                  mem_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [AXI_DATA_W-1:0] mem_wdata,
    output logic [AXI_NBYTES-1:0] mem_wstrb,
    input  logic                  mem_ready
);

    localparam logic [2:0] MAX_SIZE = 3'(AXI_BYTE_W);

    state_t                state, next_state;
    logic [AXI_ADDR_W-1:0] cur_addr, next_addr;
    logic [7:0]            len_q, beat_cnt;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [AXI_ID_W-1:0]   id_q;
    logic                  err_q;

    logic aw_fire, w_fire, last_beat;

    assign aw_fire   = axi_awvalid & axi_awready;
    assign w_fire    = axi_wvalid & axi_wready;
    assign last_beat = (beat_cnt == len_q);

    axi_burst_addr_gen #(.ADDR_W(AXI_ADDR_W)) u_addr_gen (
        .cur_addr  (cur_addr),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (axi_awvalid)          next_state = ST_WRITE;
            ST_WRITE: if (w_fire && last_beat)  next_state = ST_RESP;
            ST_RESP:  if (axi_bready)           next_state = ST_IDLE;
            default:                            next_state = ST_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = AXI_RESP_OKAY;
        mem_en      = 1'b0;
        case (state)
            ST_IDLE:  axi_awready = 1'b1;
            ST_WRITE: begin
                axi_wready = mem_ready | err_q;
                mem_en     = axi_wvalid & ~err_q;
            end
            ST_RESP: begin
                axi_bvalid = 1'b1;
                axi_bresp  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            id_q     <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else if (aw_fire) begin
            cur_addr <= axi_awaddr;
            len_q    <= axi_awlen;
            size_q   <= axi_awsize;
            burst_q  <= axi_awburst;
            id_q     <= axi_awid;
            beat_cnt <= '0;
            err_q    <= (axi_awburst == AXI_BURST_WRAP) || (axi_awsize > MAX_SIZE);
        end else if (w_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            cur_addr <= next_addr;
            // wlast must mark exactly the final beat; the burst length still rules.
            if (last_beat ? !axi_wlast : axi_wlast) err_q <= 1'b1;
        end
    end

    assign axi_bid   = id_q;
    assign mem_addr  = cur_addr[AXI_ADDR_W-1:AXI_BYTE_W];
    assign mem_wdata = axi_wdata;
    assign mem_wstrb = axi_wstrb;

endmodule

// File: tb/tb_axi_write_responder.sv
// Randomized self-checking bench for axi_write_responder: drives AW/W/B traffic
// and compares memory writes and responses against a burst-level model.
`timescale 1ns/1ps
module tb_axi_write_responder;
    import axi_write_responder_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int MW = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          axi_awvalid = 1'b0;
    logic [AW-1:0] axi_awaddr = '0;
    logic [7:0]    axi_awlen = '0;
    logic [2:0]    axi_awsize = '0;
    logic [1:0]    axi_awburst = '0;
    logic [0:0]    axi_awid = '0;
    logic          axi_awready;
    logic          axi_wvalid = 1'b0;
    logic [DW-1:0] axi_wdata = '0;
    logic [NB-1:0] axi_wstrb = '0;
    logic          axi_wlast = 1'b0;
    logic          axi_wready;
    logic          axi_bvalid;
    logic [1:0]    axi_bresp;
    logic [0:0]    axi_bid;
    logic          axi_bready = 1'b0;
    logic          mem_en;
    logic [MW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [NB-1:0] mem_wstrb;
    logic          mem_ready = 1'b1;

    axi_write_responder dut (
        .clk(clk), .reset(reset),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awid(axi_awid),
        .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wready(axi_wready),
        .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_bready(axi_bready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MW-1:0] addr;
        logic [DW-1:0] data;
        logic [NB-1:0] strb;
    } wr_t;

    int n_cmp = 0;
    int n_bad = 0;
    wr_t act_q[$];
    int mem_en_cnt = 0;
    logic [DW-1:0] wd [256];
    logic [NB-1:0] ws [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory-side monitor: a write happens whenever mem_en meets mem_ready.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_en) mem_en_cnt++;
            if (mem_en && mem_ready) act_q.push_back('{addr: mem_addr, data: mem_wdata, strb: mem_wstrb});
        end
    end

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] start, input logic [2:0] size,
                                                input logic [1:0] burst, input int i);
        logic [AW-1:0] blk;
        blk = AW'(1) << size;
        if (burst == AXI_BURST_FIXED || i == 0) return start;
        return (start / blk) * blk + AW'(i) * blk;
    endfunction

    function automatic logic wlast_of(input int i, input int len, input int early, input bit drop_last);
        return (i == len && !drop_last) || (i == early);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            wd[i] = $urandom;
            ws[i] = NB'($urandom);
        end
    endtask

    // One full AW/W/B transaction. early: beat index carrying a premature wlast
    // (-1 none); rmode: 0 mem_ready=1, 1 toggling, 2 random with wvalid gaps;
    // abort_at: beat index at which reset is pulsed instead (-1 none).
    task automatic run_burst(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic id, input int early,
                             input bit drop_last, input int rmode, input int bdelay,
                             input bit overlap, input int abort_at);
        bit   err;
        bit   static_err;
        bit   accept;
        int   beat;
        int   cyc;
        int   waits;
        int   act_base;
        int   en_base;
        logic [1:0] exp_resp;
        wr_t  rec;
        wr_t  exp_q[$];

        static_err = (burst == AXI_BURST_WRAP) || (size > 3'd2);
        err        = static_err;
        act_base   = act_q.size();
        en_base    = mem_en_cnt;

        axi_awvalid = 1'b1;
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        axi_awsize  = size;
        axi_awburst = burst;
        axi_awid    = id;
        if (overlap) begin
            axi_wvalid = 1'b1;
            axi_wdata  = wd[0];
            axi_wstrb  = ws[0];
            axi_wlast  = wlast_of(0, len, early, drop_last);
        end
        waits = 0;
        @(negedge clk);
        while (!axi_awready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("awready", axi_awready, 1'b1);
        check("wready_idle", axi_wready, 1'b0);
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        axi_awaddr  = $urandom;
        axi_awlen   = 8'($urandom);
        axi_awid    = ~id;

        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 4000) begin
            if (beat == abort_at) begin
                reset      = 1'b1;
                axi_wvalid = 1'b0;
                @(negedge clk);
                check("rst_awready", axi_awready, 1'b1);
                check("rst_wready", axi_wready, 1'b0);
                check("rst_bvalid", axi_bvalid, 1'b0);
                check("rst_mem_en", mem_en, 1'b0);
                check("rst_bresp", axi_bresp, AXI_RESP_OKAY);
                check("rst_bid", axi_bid, 1'b0);
                @(posedge clk); #1;
                reset = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("rst_no_b", axi_bvalid, 1'b0);
                end
                @(posedge clk); #1;
                return;
            end
            case (rmode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (cyc % 2 == 0);
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            axi_wvalid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi_wdata  = wd[beat];
            axi_wstrb  = ws[beat];
            axi_wlast  = wlast_of(beat, len, early, drop_last);
            @(negedge clk);
            check("wready", axi_wready, mem_ready | err);
            check("mem_en", mem_en, axi_wvalid & ~err);
            check("bvalid_in_burst", axi_bvalid, 1'b0);
            accept = axi_wvalid && (mem_ready || err);
            if (accept) begin
                if (!err) begin
                    rec.addr = MW'(beat_addr(addr, size, burst, beat) >> 2);
                    rec.data = wd[beat];
                    rec.strb = ws[beat];
                    exp_q.push_back(rec);
                end
                if (axi_wlast && beat < len) err = 1'b1;
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("w_beats", beat, len + 1);
        exp_resp   = (err || drop_last) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        mem_ready  = 1'($urandom_range(0, 1));

        waits = 0;
        @(negedge clk);
        while (!axi_bvalid && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("b_latency", waits, 0);
        check("bresp", axi_bresp, exp_resp);
        check("bid", axi_bid, id);
        for (int d = 0; d < bdelay; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bvalid_hold", axi_bvalid, 1'b1);
            check("bresp_hold", axi_bresp, exp_resp);
            check("awready_in_resp", axi_awready, 1'b0);
        end
        @(posedge clk); #1;
        axi_bready = 1'b1;
        @(negedge clk);
        check("awready_at_b_hs", axi_awready, 1'b0);
        @(posedge clk); #1;
        axi_bready = 1'b0;
        @(negedge clk);
        check("awready_after_b", axi_awready, 1'b1);
        check("bvalid_after_b", axi_bvalid, 1'b0);

        check("n_writes", act_q.size() - act_base, exp_q.size());
        foreach (exp_q[k]) begin
            if (act_base + k < act_q.size()) begin
                check("wr_addr", act_q[act_base + k].addr, exp_q[k].addr);
                check("wr_data", act_q[act_base + k].data, exp_q[k].data);
                check("wr_strb", act_q[act_base + k].strb, exp_q[k].strb);
            end
        end
        if (static_err) check("no_mem_en", mem_en_cnt - en_base, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int early;
        int r;
        logic [1:0] burst;

        repeat (2) @(negedge clk);
        check("reset_awready", axi_awready, 1'b1);
        check("reset_wready", axi_wready, 1'b0);
        check("reset_bvalid", axi_bvalid, 1'b0);
        check("reset_mem_en", mem_en, 1'b0);
        check("reset_bresp", axi_bresp, AXI_RESP_OKAY);
        check("reset_bid", axi_bid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single beat, known data: word 0x4, B two cycles after AW.
        fill_random();
        wd[0] = 32'hDEADBEEF;
        ws[0] = 4'hF;
        run_burst(32'h10, 0, 3'd2, AXI_BURST_INCR, 1'b1, -1, 1'b0, 0, 0, 1'b0, -1);

        fill_random();
        run_burst(32'h100, 7, 3'd2, AXI_BURST_INCR, 1'b0, -1, 1'b0, 0, 0, 1'b0, -1);
        fill_random();
        run_burst(32'h200, 3, 3'd2, AXI_BURST_FIXED, 1'b1, -1, 1'b0, 1, 0, 1'b0, -1);
        fill_random();
        run_burst(32'h300, 1, 3'd2, AXI_BURST_WRAP, 1'b0, -1, 1'b0, 0, 0, 1'b0, -1);
        fill_random();
        run_burst(32'h400, 3, 3'd2, AXI_BURST_INCR, 1'b1, 1, 1'b0, 0, 0, 1'b0, -1);
        fill_random();
        run_burst(32'h500, 2, 3'd2, AXI_BURST_INCR, 1'b0, -1, 1'b1, 0, 0, 1'b0, -1);
        fill_random();
        run_burst(32'h600, 1, 3'd2, AXI_BURST_INCR, 1'b1, -1, 1'b0, 0, 5, 1'b0, -1);
        fill_random();
        run_burst(32'h700, 2, 3'd2, AXI_BURST_INCR, 1'b0, -1, 1'b0, 0, 0, 1'b1, -1);
        fill_random();
        run_burst(32'h800, 7, 3'd2, AXI_BURST_INCR, 1'b1, -1, 1'b0, 0, 0, 1'b0, 2);
        fill_random();
        run_burst(32'h900, 7, 3'd2, AXI_BURST_INCR, 1'b1, -1, 1'b0, 0, 0, 1'b0, -1);
        fill_random();
        run_burst(32'h3, 5, 3'd0, AXI_BURST_INCR, 1'b0, -1, 1'b0, 0, 0, 1'b0, -1);
        fill_random();
        run_burst(32'h5, 4, 3'd1, AXI_BURST_INCR, 1'b1, -1, 1'b0, 2, 1, 1'b0, -1);
        fill_random();
        run_burst(32'h4, 1, 3'd3, AXI_BURST_INCR, 1'b0, -1, 1'b0, 0, 0, 1'b0, -1);
        fill_random();
        run_burst(32'hFFFF_FFF0, 255, 3'd2, AXI_BURST_INCR, 1'b1, -1, 1'b0, 0, 0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            fill_random();
            r     = $urandom_range(0, 9);
            burst = (r < 5) ? AXI_BURST_INCR : (r < 8) ? AXI_BURST_FIXED : AXI_BURST_WRAP;
            len   = $urandom_range(0, 31);
            early = ($urandom_range(0, 7) == 0 && len > 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_burst($urandom, len, 3'($urandom_range(0, 3)), burst, 1'($urandom),
                      early, ($urandom_range(0, 9) == 0), 2, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
